// File: rtl/fetch_unit_pkg.sv
// Shared CPU defines for the fetch stage: FSM state encoding and timeout default.
package fetch_unit_pkg;

  // Default number of cycles a memory read may stay outstanding before faulting.
  localparam int unsigned TIMEOUT_DEFAULT = 15;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StWaitMem,
    StDeliver,
    StDrain,
    StFault
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch unit: loads MAR from the PC, issues a memory read, captures the
// returned word in IR and hands it to decode. Supports stall, flush (branch redirect)
// and a sticky timeout fault for a memory that never answers.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        clear,
  input  logic [31:0] pc_in,
  output logic        inc_pc,
  output logic [31:0] mar_out,
  output logic        mem_read,
  input  logic        mem_ready,
  input  logic [31:0] mem_data,
  output logic [31:0] ir_out,
  output logic        ir_valid,
  input  logic        ir_ready,
  input  logic        stall,
  input  logic        flush,
  output logic        fault,
  output logic [15:0] fetch_count
);

  fetch_state_e r_state, w_state_d;
  logic [31:0]  r_mar, w_mar_d;
  logic [31:0]  r_ir, w_ir_d;
  logic [7:0]   r_wait_cnt, w_wait_cnt_d;
  logic [15:0]  r_fetch_count, w_fetch_count_d;
  logic         w_timeout;

  // Last permitted wait cycle: without mem_ready here the read is abandoned.
  assign w_timeout = (r_wait_cnt == 8'(TIMEOUT - 1));

  assign mar_out     = r_mar;
  assign ir_out      = r_ir;
  assign fetch_count = r_fetch_count;

  // Next-state and output decode.
  always_comb begin
    w_state_d       = r_state;
    w_mar_d         = r_mar;
    w_ir_d          = r_ir;
    w_wait_cnt_d    = r_wait_cnt;
    w_fetch_count_d = r_fetch_count;
    mem_read        = 1'b0;
    inc_pc          = 1'b0;
    ir_valid        = 1'b0;
    fault           = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (!stall) w_state_d = StAddr;
      end
      StAddr: begin
        w_mar_d = pc_in;
        if (flush) begin
          w_state_d = StAddr;
        end else if (!stall) begin
          w_state_d    = StWaitMem;
          w_wait_cnt_d = 8'd0;
        end else begin
          w_state_d = StIdle;
        end
      end
      StWaitMem: begin
        mem_read     = 1'b1;
        w_wait_cnt_d = r_wait_cnt + 8'd1;
        if (flush) begin
          // Redirected: a read already answered is dropped, otherwise drain it.
          if (mem_ready) begin
            w_state_d = StAddr;
          end else begin
            w_state_d    = StDrain;
            w_wait_cnt_d = 8'd0;
          end
        end else if (mem_ready) begin
          w_ir_d    = mem_data;
          inc_pc    = 1'b1;
          w_state_d = StDeliver;
        end else if (w_timeout) begin
          w_state_d = StFault;
        end
      end
      StDrain: begin
        mem_read     = 1'b1;
        w_wait_cnt_d = r_wait_cnt + 8'd1;
        if (mem_ready) begin
          w_state_d = StAddr;
        end else if (w_timeout) begin
          w_state_d = StFault;
        end
      end
      StDeliver: begin
        ir_valid = 1'b1;
        if (flush) begin
          w_state_d = StAddr;
        end else if (ir_ready) begin
          w_fetch_count_d = r_fetch_count + 16'd1;
          w_state_d       = stall ? StIdle : StAddr;
        end
      end
      StFault: begin
        fault = 1'b1;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously by clear.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      r_state       <= StIdle;
      r_mar         <= 32'd0;
      r_ir          <= 32'd0;
      r_wait_cnt    <= 8'd0;
      r_fetch_count <= 16'd0;
    end else begin
      r_state       <= w_state_d;
      r_mar         <= w_mar_d;
      r_ir          <= w_ir_d;
      r_wait_cnt    <= w_wait_cnt_d;
      r_fetch_count <= w_fetch_count_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: table-driven fetches plus hand-written corner cases.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        clear;
  logic [31:0] pc_in;
  logic        inc_pc;
  logic [31:0] mar_out;
  logic        mem_read;
  logic        mem_ready;
  logic [31:0] mem_data;
  logic [31:0] ir_out;
  logic        ir_valid;
  logic        ir_ready;
  logic        stall;
  logic        flush;
  logic        fault;
  logic [15:0] fetch_count;

  fetch_unit #(.TIMEOUT(15)) dut (
    .clk        (clk),
    .clear      (clear),
    .pc_in      (pc_in),
    .inc_pc     (inc_pc),
    .mar_out    (mar_out),
    .mem_read   (mem_read),
    .mem_ready  (mem_ready),
    .mem_data   (mem_data),
    .ir_out     (ir_out),
    .ir_valid   (ir_valid),
    .ir_ready   (ir_ready),
    .stall      (stall),
    .flush      (flush),
    .fault      (fault),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    int          mem_delay;
    int          acc_delay;
    bit          stall_wait;
    logic [31:0] exp_mar;
    logic [31:0] exp_ir;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          n_inc = 0;
  int          inc_base = 0;
  int          exp_inc = 0;
  logic [15:0] model_count = 16'd0;
  logic [31:0] exp_q[$];
  vec_t        vecs[5];

  // Count inc_pc pulses as seen by the pc block on each rising edge.
  always @(posedge clk) if (inc_pc === 1'b1) n_inc++;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_inc(input string name);
    check32(name, 32'(n_inc - inc_base), 32'(exp_inc));
  endtask

  task automatic check_reset_vals(input string tag);
    check32({tag, "_mar"}, mar_out, 32'd0);
    check32({tag, "_ir"}, ir_out, 32'd0);
    check1({tag, "_ir_valid"}, ir_valid, 1'b0);
    check1({tag, "_inc_pc"}, inc_pc, 1'b0);
    check1({tag, "_mem_read"}, mem_read, 1'b0);
    check1({tag, "_fault"}, fault, 1'b0);
    check32({tag, "_count"}, {16'd0, fetch_count}, 32'd0);
  endtask

  task automatic wait_mem_read(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_read === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL wait_mem_read: mem_read=%b after 20 cycles, expected 1", mem_read);
    end
  endtask

  // Drive a PC and wait for the read to start; MAR must hold that PC.
  task automatic start_fetch(input logic [31:0] pc, input logic [31:0] exp_mar, output bit ok);
    pc_in     = pc;
    stall     = 1'b0;
    flush     = 1'b0;
    mem_ready = 1'b0;
    ir_ready  = 1'b0;
    wait_mem_read(ok);
    if (ok) check32("mar_out", mar_out, exp_mar);
  endtask

  // Answer the outstanding read after mem_delay cycles, accept after acc_delay cycles.
  task automatic complete_fetch(input logic [31:0] data, input logic [31:0] exp_ir,
                                input int mem_delay, input int acc_delay);
    logic [31:0] exp;
    for (int i = 0; i < mem_delay; i++) begin
      @(negedge clk);
      check1("mem_read_wait", mem_read, 1'b1);
      check1("ir_valid_wait", ir_valid, 1'b0);
    end
    mem_ready = 1'b1;
    mem_data  = data;
    exp_q.push_back(exp_ir);
    exp_inc++;
    #1 check1("inc_pc_load", inc_pc, 1'b1);
    @(negedge clk);
    mem_ready = 1'b0;
    mem_data  = $urandom;
    check1("ir_valid_deliver", ir_valid, 1'b1);
    check1("mem_read_deliver", mem_read, 1'b0);
    for (int i = 0; i < acc_delay; i++) begin
      @(negedge clk);
      check1("ir_valid_held", ir_valid, 1'b1);
      check32("ir_out_held", ir_out, exp_q[0]);
      check1("mem_read_held", mem_read, 1'b0);
    end
    ir_ready = 1'b1;
    exp = exp_q.pop_front();
    check32("ir_out", ir_out, exp);
    model_count++;
    @(negedge clk);
    ir_ready = 1'b0;
    check32("fetch_count", {16'd0, fetch_count}, {16'd0, model_count});
    check1("ir_valid_after", ir_valid, 1'b0);
    check_inc("inc_pc_total");
  endtask

  initial begin
    bit ok;
    int gap;
    int n_wait;
    bit found;

    vecs[0] = '{32'h0000_0010, 32'hA5A5_A5A5, 0, 0, 1'b0, 32'h0000_0010, 32'hA5A5_A5A5};
    vecs[1] = '{32'h0000_0014, 32'h1234_5678, 0, 5, 1'b0, 32'h0000_0014, 32'h1234_5678};
    vecs[2] = '{32'h0000_0018, 32'hDEAD_BEEF, 3, 1, 1'b0, 32'h0000_0018, 32'hDEAD_BEEF};
    vecs[3] = '{32'h0000_001C, 32'h0F0F_0F0F, 14, 0, 1'b0, 32'h0000_001C, 32'h0F0F_0F0F};
    vecs[4] = '{32'h0000_0020, 32'hCAFE_F00D, 2, 0, 1'b1, 32'h0000_0020, 32'hCAFE_F00D};

    clear     = 1'b0;
    pc_in     = 32'd0;
    mem_ready = 1'b0;
    mem_data  = 32'd0;
    ir_ready  = 1'b0;
    stall     = 1'b0;
    flush     = 1'b0;
    #12;
    check_reset_vals("reset");
    @(negedge clk);
    clear    = 1'b1;
    inc_base = n_inc;

    // Table-driven fetches.
    for (int i = 0; i < 5; i++) begin
      start_fetch(vecs[i].pc, vecs[i].exp_mar, ok);
      if (!ok) continue;
      if (vecs[i].stall_wait) stall = 1'b1;
      complete_fetch(vecs[i].data, vecs[i].exp_ir, vecs[i].mem_delay, vecs[i].acc_delay);
      if (vecs[i].stall_wait) begin
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check1("stall_park_mem_read", mem_read, 1'b0);
          check1("stall_park_ir_valid", ir_valid, 1'b0);
        end
        stall = 1'b0;
      end
    end

    // Flush during WAIT_MEM, data arrives two cycles later in DRAIN and is dropped.
    start_fetch(32'h0000_0100, 32'h0000_0100, ok);
    flush = 1'b1;
    #1 check1("flush_wait_inc", inc_pc, 1'b0);
    @(negedge clk);
    flush = 1'b0;
    check1("drain_mem_read1", mem_read, 1'b1);
    check1("drain_ir_valid", ir_valid, 1'b0);
    @(negedge clk);
    check1("drain_mem_read2", mem_read, 1'b1);
    mem_ready = 1'b1;
    mem_data  = 32'hBAD0_BAD0;
    #1 check1("drain_inc", inc_pc, 1'b0);
    @(negedge clk);
    mem_ready = 1'b0;
    check1("after_drain_ir_valid", ir_valid, 1'b0);
    check1("after_drain_mem_read", mem_read, 1'b0);
    start_fetch(32'h0000_0200, 32'h0000_0200, ok);
    complete_fetch(32'h600D_F00D, 32'h600D_F00D, 0, 0);

    // Flush in DELIVER beats ir_ready: instruction dropped, not counted.
    start_fetch(32'h0000_0040, 32'h0000_0040, ok);
    mem_ready = 1'b1;
    mem_data  = 32'h1111_2222;
    exp_inc++;
    #1 check1("flush_deliver_load_inc", inc_pc, 1'b1);
    @(negedge clk);
    mem_ready = 1'b0;
    check32("flush_deliver_ir", ir_out, 32'h1111_2222);
    flush    = 1'b1;
    ir_ready = 1'b1;
    @(negedge clk);
    flush    = 1'b0;
    ir_ready = 1'b0;
    check1("flush_deliver_ir_valid", ir_valid, 1'b0);
    check32("flush_deliver_count", {16'd0, fetch_count}, {16'd0, model_count});
    start_fetch(32'h0000_0044, 32'h0000_0044, ok);
    complete_fetch(32'h3333_4444, 32'h3333_4444, 0, 0);

    // fetch_count wrap: park in IDLE, preload 0xFFFF, deliver once.
    stall = 1'b1;
    @(negedge clk);
    @(negedge clk);
    force dut.r_fetch_count = 16'hFFFF;
    #1 release dut.r_fetch_count;
    model_count = 16'hFFFF;
    start_fetch(32'h0000_0050, 32'h0000_0050, ok);
    complete_fetch(32'h5555_AAAA, 32'h5555_AAAA, 0, 0);

    // Back-to-back throughput with memory and decode always ready.
    mem_data  = 32'h1357_9BDF;
    mem_ready = 1'b1;
    ir_ready  = 1'b1;
    found     = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (inc_pc === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    check1("throughput_first_pulse", found, 1'b1);
    gap = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      gap++;
      if (inc_pc === 1'b1) break;
    end
    check32("throughput_gap", 32'(gap), 32'd3);

    // Asynchronous clear from an arbitrary point.
    clear     = 1'b0;
    mem_ready = 1'b0;
    ir_ready  = 1'b0;
    #1 check_reset_vals("clear_mid");
    @(negedge clk);
    clear       = 1'b1;
    model_count = 16'd0;
    exp_q.delete();
    inc_base = n_inc;
    exp_inc  = 0;

    // Clear asserted in the same cycle memory answers: no inc_pc pulse.
    start_fetch(32'h0000_0300, 32'h0000_0300, ok);
    mem_ready = 1'b1;
    mem_data  = 32'h7777_7777;
    clear     = 1'b0;
    #1;
    check1("clear_fetch_inc", inc_pc, 1'b0);
    check1("clear_fetch_mem_read", mem_read, 1'b0);
    check32("clear_fetch_mar", mar_out, 32'd0);
    @(negedge clk);
    mem_ready = 1'b0;
    check_inc("clear_fetch_inc_total");
    clear    = 1'b1;
    inc_base = n_inc;

    // Memory never answers: fault after 15 WAIT_MEM cycles, sticky until clear.
    start_fetch(32'h0000_0400, 32'h0000_0400, ok);
    n_wait = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (fault === 1'b1) break;
      if (mem_read === 1'b1) n_wait++;
    end
    check32("timeout_cycles", 32'(n_wait), 32'd15);
    check1("timeout_fault", fault, 1'b1);
    check1("timeout_mem_read", mem_read, 1'b0);
    check1("timeout_ir_valid", ir_valid, 1'b0);
    repeat (3) @(negedge clk);
    check1("fault_sticky", fault, 1'b1);
    check1("fault_mem_read", mem_read, 1'b0);
    check_inc("fault_inc_total");
    clear = 1'b0;
    #1 check_reset_vals("fault_clear");
    @(negedge clk);
    clear = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: TIMEOUT, 15, maximum cycles spent in WAIT_MEM before fault (range 1..255).
REQ-002 Port: clk  in  1  rising-edge clock; all state changes on posedge clk.
REQ-003 Port: clear  in  1  reset, asynchronous, active-low.
REQ-004 Port: pc_in  in  32  current PC value from the pc block (pc_out).
REQ-005 Port: inc_pc  out  1  one-cycle pulse to the pc block incPC input.
REQ-006 Port: mar_out  out  32  memory address register, drives memory address bus.
REQ-007 Port: mem_read  out  1  memory read request.
REQ-008 Port: mem_ready  in  1  memory has valid data on mem_data this cycle.
REQ-009 Port: mem_data  in  32  memory read data.
REQ-010 Port: ir_out  out  32  instruction register contents.
REQ-011 Port: ir_valid  out  1  ir_out holds an undelivered instruction.
REQ-012 Port: ir_ready  in  1  decode stage accepts ir_out this cycle.
REQ-013 Port: stall  in  1  suppress start of a new fetch.
REQ-014 Port: flush  in  1  discard in-flight/held instruction (branch redirect).
REQ-015 Port: fault  out  1  sticky memory-timeout flag.
REQ-016 Port: fetch_count  out  16  count of delivered instructions.

Function
REQ-017 FSM states SHALL be IDLE, ADDR, WAIT_MEM, DELIVER, DRAIN, FAULT.
REQ-018 IDLE: stall=0 -> ADDR; else remain.
REQ-019 ADDR: mar_out <= pc_in; -> WAIT_MEM if stall=0, else IDLE (MAR still loaded); flush in ADDR -> ADDR again.
REQ-020 WAIT_MEM: mem_read=1 (combinational from state); wait counter increments per cycle.
REQ-021 WAIT_MEM with mem_ready=1, flush=0: ir_out <= mem_data, inc_pc=1 this cycle only, -> DELIVER.
REQ-022 WAIT_MEM with flush=1 (any mem_ready): no IR load, no inc_pc; -> ADDR if mem_ready=1, else DRAIN.
REQ-023 DRAIN: mem_read=1; on mem_ready=1 discard data -> ADDR; flush in DRAIN ignored.
REQ-024 Wait counter SHALL reset to 0 on entering WAIT_MEM/DRAIN; reaching TIMEOUT without mem_ready -> FAULT, fault=1.
REQ-025 FAULT: mem_read=0, inc_pc=0, ir_valid=0; exit only by clear.
REQ-026 DELIVER: ir_valid=1; ir_out stable until accepted.
REQ-027 DELIVER with ir_ready=1, flush=0: fetch_count += 1 (wraps 0xFFFF -> 0x0000); -> ADDR if stall=0, else IDLE.
REQ-028 DELIVER with flush=1: ir_valid drops next cycle, no count, -> ADDR (flush beats ir_ready).
REQ-029 stall SHALL never abort a fetch already in WAIT_MEM/DRAIN/DELIVER.
REQ-030 Minimum throughput: 3 cycles/instruction (ADDR, WAIT_MEM, DELIVER) with mem_ready and ir_ready held 1.
REQ-031 inc_pc SHALL pulse exactly once per instruction loaded into IR; never in other cases.

Reset
REQ-032 clear=0 SHALL immediately force state IDLE, mar_out=0, ir_out=0, ir_valid=0, inc_pc=0, mem_read=0, fault=0, fetch_count=0, wait counter=0.
REQ-033 Reset mid-fetch SHALL drop any request; no inc_pc pulse generated on or after reset assertion.

Structure
REQ-034 State encoding and TIMEOUT default SHALL live in the shared CPU defines package.
REQ-035 Single module; no sub-modules required (wait counter and fetch_count inline).

Verification
REQ-036 clear low then high, pc_in=0x00000010, mem_ready=1 same cycle as WAIT_MEM, mem_data=0xA5A5A5A5, ir_ready=1 -> mar_out=0x10, one inc_pc pulse, ir_out=0xA5A5A5A5, fetch_count=1 after 3 cycles.
REQ-037 ir_ready=0 for 5 cycles in DELIVER -> ir_valid held, ir_out unchanged, no second mem_read, no extra inc_pc.
REQ-038 flush during WAIT_MEM with mem_ready delayed 2 cycles -> DRAIN, data discarded, no inc_pc, next ADDR reloads pc_in.
REQ-039 mem_ready never asserted, TIMEOUT=15 -> fault=1 after 15 WAIT_MEM cycles, mem_read=0 afterwards; clear restores fault=0.
REQ-040 fetch_count preloaded to 0xFFFF via 65535 deliveries (or forced) then one delivery -> 0x0000.
REQ-041 stall=1 asserted in WAIT_MEM -> fetch completes and delivers, then FSM parks in IDLE until stall=0.
